// File: rtl/char_tx_arbiter_if.sv
// Handshake and serial-line bundle for char_tx_arbiter.
// Two requester valid/ready/char channels plus line and status outputs.
//
// Signals:
//   req0Valid/req0Char/req0Ready : keyboard requester channel
//   req1Valid/req1Char/req1Ready : Morse decoder requester channel
//   txBit      : serial line into CharReceiver, idles high
//   busy       : arbiter is not idle
//   lastGrant  : index of the most recently accepted requester
//   frameCount : completed frames, wraps at 256
interface char_tx_arbiter_if;
    logic       req0Valid;
    logic [7:0] req0Char;
    logic       req0Ready;
    logic       req1Valid;
    logic [7:0] req1Char;
    logic       req1Ready;
    logic       txBit;
    logic       busy;
    logic       lastGrant;
    logic [7:0] frameCount;

    // Arbiter side.
    modport slave (
        input  req0Valid,
        input  req0Char,
        input  req1Valid,
        input  req1Char,
        output req0Ready,
        output req1Ready,
        output txBit,
        output busy,
        output lastGrant,
        output frameCount
    );

    // Requester / observer side.
    modport master (
        output req0Valid,
        output req0Char,
        output req1Valid,
        output req1Char,
        input  req0Ready,
        input  req1Ready,
        input  txBit,
        input  busy,
        input  lastGrant,
        input  frameCount
    );
endinterface

// File: rtl/char_tx_arbiter.sv
// Round-robin arbiter serializing one 8-bit character per frame
// (start 0, 8 data bits LSB first, stop 1) followed by an idle gap.
//
// Ports:
//   cclk : clock, rising edge
//   rstb : asynchronous active-low reset
//   bus  : char_tx_arbiter_if.slave (requesters, txBit, status)
// Parameters:
//   BIT_CYCLES : clocks each frame bit is held (>= 1)
//   GAP_CYCLES : idle-high clocks after the stop bit (>= 0)
module char_tx_arbiter #(
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic             cclk,
    input  logic             rstb,
    char_tx_arbiter_if.slave bus
);

    localparam int BW = $clog2(BIT_CYCLES) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST =
        (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q,   idx_d;
    logic [BW-1:0] bcnt_q,  bcnt_d;
    logic [GW-1:0] gcnt_q,  gcnt_d;
    logic          tx_q,    tx_d;
    logic          lg_q,    lg_d;
    logic [7:0]    fc_q,    fc_d;

    logic grant_vld;
    logic grant_idx;
    logic idle;
    logic bit_done;

    assign idle     = (state_q == S_IDLE);
    assign bit_done = (bcnt_q == BIT_LAST);

    // Round-robin: on contention the requester not served last wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        unique case (1'b1)
            (bus.req0Valid && bus.req1Valid): begin
                grant_vld = 1'b1;
                grant_idx = ~lg_q;
            end
            (bus.req0Valid && !bus.req1Valid): begin
                grant_vld = 1'b1;
                grant_idx = 1'b0;
            end
            (!bus.req0Valid && bus.req1Valid): begin
                grant_vld = 1'b1;
                grant_idx = 1'b1;
            end
            default: begin
                grant_vld = 1'b0;
                grant_idx = 1'b0;
            end
        endcase
    end

    // rstb gates ready so no handshake is offered while reset is held.
    assign bus.req0Ready = rstb && idle && grant_vld && !grant_idx;
    assign bus.req1Ready = rstb && idle && grant_vld && grant_idx;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        lg_d    = lg_q;
        fc_d    = fc_q;
        tx_d    = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    shift_d = grant_idx ? bus.req1Char : bus.req0Char;
                    lg_d    = grant_idx;
                    bcnt_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    bcnt_d  = '0;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    bcnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    bcnt_d = '0;
                    fc_d   = fc_q + 8'd1;
                    gcnt_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    gcnt_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line level is registered: derive it from where we are heading.
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            tx_q    <= 1'b1;
            lg_q    <= 1'b1;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            tx_q    <= tx_d;
            lg_q    <= lg_d;
            fc_q    <= fc_d;
        end
    end

    assign bus.txBit      = tx_q;
    assign bus.busy       = !idle;
    assign bus.lastGrant  = lg_q;
    assign bus.frameCount = fc_q;

endmodule

// File: tb/tb_char_tx_arbiter.sv
// Bench for char_tx_arbiter: two instances (B=1,G=16 and B=3,G=0)
// driven by shared requesters, checked against a frame-offset model.
`timescale 1ns/1ps
module tb_char_tx_arbiter;

    logic       clk  = 1'b0;
    logic       rstb = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] c0 = 8'h00, c1 = 8'h00;

    always #5 clk = ~clk;

    char_tx_arbiter_if ifa ();
    char_tx_arbiter_if ifb ();

    assign ifa.req0Valid = v0;
    assign ifa.req0Char  = c0;
    assign ifa.req1Valid = v1;
    assign ifa.req1Char  = c1;
    assign ifb.req0Valid = v0;
    assign ifb.req0Char  = c0;
    assign ifb.req1Valid = v1;
    assign ifb.req1Char  = c1;

    char_tx_arbiter #(.BIT_CYCLES(1), .GAP_CYCLES(16)) dut_a (
        .cclk(clk), .rstb(rstb), .bus(ifa)
    );
    char_tx_arbiter #(.BIT_CYCLES(3), .GAP_CYCLES(0)) dut_b (
        .cclk(clk), .rstb(rstb), .bus(ifb)
    );

    logic       rdy0[2], rdy1[2], txb[2], bsy[2], lgo[2];
    logic [7:0] fco[2];
    assign rdy0[0] = ifa.req0Ready;  assign rdy0[1] = ifb.req0Ready;
    assign rdy1[0] = ifa.req1Ready;  assign rdy1[1] = ifb.req1Ready;
    assign txb[0]  = ifa.txBit;      assign txb[1]  = ifb.txBit;
    assign bsy[0]  = ifa.busy;       assign bsy[1]  = ifb.busy;
    assign lgo[0]  = ifa.lastGrant;  assign lgo[1]  = ifb.lastGrant;
    assign fco[0]  = ifa.frameCount; assign fco[1]  = ifb.frameCount;

    int pb[2] = '{1, 3};
    int pg[2] = '{16, 0};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a frame is described by its accept cycle and character;
    // every output follows from the offset into that frame.
    int         cyc = 0;
    bit         mact[2] = '{1'b0, 1'b0};
    int         mT[2]   = '{0, 0};
    logic [7:0] mch[2]  = '{8'h00, 8'h00};
    logic       mlg[2]  = '{1'b1, 1'b1};
    logic [7:0] mfc[2]  = '{8'h00, 8'h00};

    function automatic bit in_frame(input int d);
        int o;
        o = cyc - mT[d];
        return mact[d] && (o >= 1) && (o <= 10 * pb[d] + pg[d]);
    endfunction

    function automatic logic exp_tx(input int d);
        int o;
        o = cyc - mT[d];
        if (!in_frame(d)) return 1'b1;
        if (o <= pb[d]) return 1'b0;
        if (o <= 9 * pb[d]) return mch[d][(o - 1) / pb[d] - 1];
        return 1'b1;
    endfunction

    function automatic int grant_of(input int d);
        if (v0 && v1) return mlg[d] ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rstb) begin
                mact[d] <= 1'b0;
                mlg[d]  <= 1'b1;
                mfc[d]  <= 8'h00;
            end else begin
                if (mact[d] && (cyc - mT[d] == 10 * pb[d]))
                    mfc[d] <= mfc[d] + 8'd1;
                if (!in_frame(d) && grant_of(d) >= 0) begin
                    mact[d] <= 1'b1;
                    mT[d]   <= cyc;
                    mch[d]  <= (grant_of(d) == 1) ? c1 : c0;
                    mlg[d]  <= (grant_of(d) == 1);
                end
            end
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rstb) begin
                chk($sformatf("rst_tx%0d", d),   32'(txb[d]),  32'd1);
                chk($sformatf("rst_busy%0d", d), 32'(bsy[d]),  32'd0);
                chk($sformatf("rst_rdy0_%0d", d), 32'(rdy0[d]), 32'd0);
                chk($sformatf("rst_rdy1_%0d", d), 32'(rdy1[d]), 32'd0);
                chk($sformatf("rst_lg%0d", d),   32'(lgo[d]),  32'd1);
                chk($sformatf("rst_fc%0d", d),   32'(fco[d]),  32'd0);
            end else begin
                chk($sformatf("tx%0d", d),   32'(txb[d]), 32'(exp_tx(d)));
                chk($sformatf("busy%0d", d), 32'(bsy[d]), 32'(in_frame(d)));
                chk($sformatf("rdy0_%0d", d), 32'(rdy0[d]),
                    32'(!in_frame(d) && grant_of(d) == 0));
                chk($sformatf("rdy1_%0d", d), 32'(rdy1[d]),
                    32'(!in_frame(d) && grant_of(d) == 1));
                chk($sformatf("lg%0d", d), 32'(lgo[d]), 32'(mlg[d]));
                chk($sformatf("fc%0d", d), 32'(fco[d]), 32'(mfc[d]));
            end
        end
    end

    // Observed accepts (cycle of the accept edge, requester index).
    int accA_c[$], accA_g[$], accB_c[$], accB_g[$];

    always @(negedge clk) begin
        if (rstb) begin
            if (ifa.req0Valid && ifa.req0Ready) begin
                accA_c.push_back(cyc); accA_g.push_back(0);
            end
            if (ifa.req1Valid && ifa.req1Ready) begin
                accA_c.push_back(cyc); accA_g.push_back(1);
            end
            if (ifb.req0Valid && ifb.req0Ready) begin
                accB_c.push_back(cyc); accB_g.push_back(0);
            end
            if (ifb.req1Valid && ifb.req1Ready) begin
                accB_c.push_back(cyc); accB_g.push_back(1);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rstb = 1'b0; v0 = 1'b0; v1 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        accA_c.delete(); accA_g.delete();
        accB_c.delete(); accB_g.delete();
        rstb = 1'b1;
    endtask

    task automatic wait_acc(input int d, input int n, input int bound);
        int k;
        int sz;
        k = 0;
        sz = (d == 0) ? accA_c.size() : accB_c.size();
        while (sz < n && k < bound) begin
            @(negedge clk); #1;
            k++;
            sz = (d == 0) ? accA_c.size() : accB_c.size();
        end
        chk($sformatf("acc_wait%0d", d), sz, n);
    endtask

    logic [9:0]  bits10;
    logic [29:0] bits30;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_tx",   32'(ifa.txBit),      32'd1);
        chk("reset_busy", 32'(ifa.busy),       32'd0);
        chk("reset_lg",   32'(ifa.lastGrant),  32'd1);
        chk("reset_fc",   32'(ifa.frameCount), 32'd0);
        rstb = 1'b1;

        // Single frame of 8'h03.
        do_reset();
        c0 = 8'h03; v0 = 1'b1;
        wait_acc(0, 1, 100);
        @(posedge clk); #2; v0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); bits10[i] = ifa.txBit;
        end
        chk("single_bits", 32'(bits10), 32'(10'b10_0000_0110));
        repeat (16) @(negedge clk);
        chk("single_busy26", 32'(ifa.busy), 32'd1);
        @(negedge clk);
        chk("single_busy27", 32'(ifa.busy), 32'd0);
        chk("single_fc", 32'(ifa.frameCount), 32'd1);

        // Contention after reset alternates, 27 cycles apart.
        do_reset();
        c0 = 8'h01; c1 = 8'h02; v0 = 1'b1; v1 = 1'b1;
        wait_acc(0, 4, 200);
        for (int i = 0; i < 4; i++)
            chk($sformatf("cont_grant%0d", i), accA_g[i], i % 2);
        for (int i = 1; i < 4; i++)
            chk($sformatf("cont_gap%0d", i), accA_c[i] - accA_c[i-1], 27);
        @(posedge clk); #2; v0 = 1'b0; v1 = 1'b0;
        chk("cont_lg", 32'(ifa.lastGrant), 32'd1);
        repeat (30) @(negedge clk);

        // Sole requester 1 repeats without stalls.
        do_reset();
        c1 = 8'h5A; v1 = 1'b1;
        wait_acc(0, 4, 200);
        for (int i = 0; i < 4; i++)
            chk($sformatf("sole_grant%0d", i), accA_g[i], 1);
        for (int i = 1; i < 4; i++)
            chk($sformatf("sole_gap%0d", i), accA_c[i] - accA_c[i-1], 27);
        @(posedge clk); #2; v1 = 1'b0;
        repeat (12) @(negedge clk);
        chk("sole_fc", 32'(ifa.frameCount), 32'd4);
        repeat (40) @(negedge clk);

        // Reset during data bit 3 of 8'hA5.
        do_reset();
        c0 = 8'hA5; v0 = 1'b1;
        wait_acc(0, 1, 100);
        @(posedge clk); #2; v0 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("mid_bit3", 32'(ifa.txBit), 32'd0);
        rstb = 1'b0; c0 = 8'h07; v0 = 1'b1;
        #1;
        chk("mid_rst_tx",   32'(ifa.txBit),     32'd1);
        chk("mid_rst_busy", 32'(ifa.busy),      32'd0);
        chk("mid_rst_rdy",  32'(ifa.req0Ready), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        accA_c.delete(); accA_g.delete();
        accB_c.delete(); accB_g.delete();
        rstb = 1'b1;
        wait_acc(0, 1, 100);
        @(posedge clk); #2; v0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); bits10[i] = ifa.txBit;
        end
        chk("mid_bits", 32'(bits10), 32'(10'b10_0000_1110));
        @(negedge clk);
        chk("mid_fc", 32'(ifa.frameCount), 32'd1);
        repeat (40) @(negedge clk);

        // B=3, G=0 instance: 30-cycle frame, next accept at T+31.
        do_reset();
        c0 = 8'h05; v0 = 1'b1;
        wait_acc(1, 1, 100);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); bits30[i] = ifb.txBit;
        end
        chk("sweep_bits", 32'(bits30),
            32'(30'b111_000000000000000_111_000_111_000));
        wait_acc(1, 2, 10);
        chk("sweep_gap", accB_c[1] - accB_c[0], 31);
        @(posedge clk); #2; v0 = 1'b0;
        repeat (40) @(negedge clk);

        // 256 frames wrap frameCount back to 0.
        do_reset();
        c0 = 8'h01; v0 = 1'b1;
        wait_acc(0, 256, 256 * 27 + 200);
        @(posedge clk); #2; v0 = 1'b0;
        repeat (10) @(negedge clk);
        chk("wrap_fc255", 32'(ifa.frameCount), 32'd255);
        @(negedge clk);
        chk("wrap_fc0", 32'(ifa.frameCount), 32'd0);
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/char_tx_arbiter.md
# char_tx_arbiter

Shares the single serial character link into `CharReceiver` between two character sources: requester 0 is the local keyboard path and requester 1 is the Morse decoder. Each source offers one 8-bit character at a time through a valid/ready handshake. The block arbitrates round-robin and serializes the winning character as one frame: start bit 0, 8 data bits LSB first, stop bit 1. It then enforces an idle gap so the receiver can store the character before the next frame.

## Interface
- `BIT_CYCLES`, default 1: clocks each frame bit is held (1 matches the receiver's one-bit-per-`cclk` sampling); legal range ≥1.
- `GAP_CYCLES`, default 16: idle-high clocks inserted after the stop bit; 0 legal.
- `cclk` in 1: the single clock, rising edge.
- `rstb` in 1: reset, asynchronous, active-low.
- `req0Valid` in 1: requester 0 has a character.
- `req0Char` in 8: requester 0 character; must be stable while `req0Valid` is high.
- `req0Ready` out 1: requester 0 character is accepted on this edge.
- `req1Valid` in 1, `req1Char` in 8, `req1Ready` out 1: the same for requester 1.
- `txBit` out 1: serial line to `CharReceiver.inputCharBit`; idles high; registered.
- `busy` out 1: high whenever the state is not IDLE.
- `lastGrant` out 1: index of the most recently accepted requester.
- `frameCount` out 8: count of frames whose stop bit has completed; wraps 255→0.

## Operation
- States: IDLE, START, DATA, STOP, GAP.
- **IDLE:** `txBit`=1.
  - Grant selection, combinational: only one valid → that requester; both valid → the requester ≠ `lastGrant`; none → no grant.
  - `reqNReady` = (state==IDLE) && grant==N.
  - A transfer occurs on the edge where `reqNValid && reqNReady`. On that edge: latch `reqNChar` into the shift register, set `lastGrant`=N, go to START.
  - `reqNReady` depends combinationally on the valid inputs. Requesters must not derive valid from ready.
- **START:** `txBit`=0 for `BIT_CYCLES` clocks, then go to DATA with bit index 0.
- **DATA:** `txBit` = shift[index], held `BIT_CYCLES` clocks per bit, index 0..7. After index 7 go to STOP.
- **STOP:** `txBit`=1 for `BIT_CYCLES` clocks.
  - On leaving STOP, increment `frameCount` (8-bit wrap).
  - Then go to GAP, or directly to IDLE if `GAP_CYCLES`=0.
- **GAP:** `txBit`=1 for `GAP_CYCLES` clocks, then go to IDLE.
- Both readys stay 0 outside IDLE. Valid inputs are ignored until IDLE, so a requester may hold valid through an entire frame.
- Bit-hold counter: width ≥ clog2(`BIT_CYCLES`)+1. Gap counter: width ≥ clog2(`GAP_CYCLES`+1)+1. Neither counter may wrap early.
- **Reset (asynchronous, any time, including mid-frame):**
  - Immediately: state=IDLE, `txBit`=1, `busy`=0, both readys=0, `lastGrant`=1 (so requester 0 wins the first contention), `frameCount`=0, shift register=0.
  - A partially sent character is discarded and is not retransmitted.

## Timing
- Accept edge T, with `BIT_CYCLES`=B and `GAP_CYCLES`=G:
  - start bit drives `txBit` in cycles T+1 .. T+B;
  - data bit k drives `txBit` in cycles T+1+(k+1)B .. T+(k+2)B;
  - stop bit drives `txBit` in cycles T+1+9B .. T+10B;
  - GAP occupies the next G cycles;
  - IDLE is first reached at cycle T+10B+G+1, and a new accept can happen on that cycle's edge.
- Minimum spacing between accepts is 10B+G+1 clocks. For B=1, G=16 that is 27.
- `busy` rises in cycle T+1 and falls in the first IDLE cycle.
- `frameCount` updates on the edge that ends STOP.
- `lastGrant` updates on the accept edge T.
- With G=0, `txBit` stays high from the stop bit straight into IDLE. A back-to-back accept then gives exactly 1 stop bit plus 1 idle-high cycle between frames.

## Test plan
- **Single frame:** reset, then `req0Valid`=1 with `req0Char`=8'h03, B=1, G=16 → `req0Ready` high for exactly 1 cycle; `txBit` = 0,1,1,0,0,0,0,0,0,1 over cycles T+1..T+10; then high; `frameCount`=1; `busy` low at T+27.
- **Contention after reset:** both valid, `req0Char`=8'h01, `req1Char`=8'h02, held high → accepts alternate 0,1,0,1; frames carry 01,02,01,02; accepts are exactly 27 cycles apart; `lastGrant` toggles each accept.
- **Sole requester repeats:** only `req1Valid` high for 4 frames → all 4 granted to requester 1 with no starvation stall; `frameCount`=4.
- **Reset mid-frame:** assert `rstb`=0 during data bit 3 → `txBit`=1 within the same cycle, no ready pulses; after release and a new req0 char 8'h07, a clean frame is sent and `frameCount`=1.
- **Parameter sweep:** B=3, G=0 with char 8'h05 → each bit is held 3 cycles; frame length is 30 cycles; the next accept occurs at T+31.
- **Wrap:** 256 frames of 8'h01 → `frameCount` returns to 0; an end-to-end check with `CharReceiver` stores 8'h01 in successive char slots.
